sub_result_stage: RTL and testbench
===================================

Name: sub_result_stage

Overview:
- Registered output stage directly downstream of the 4-bit subtractor.
- Captures operands A, B and difference Y, computes status flags at capture, and holds results in a 2-entry buffer with valid/ready handshakes on both sides.
- Maintains a sticky signed-overflow flag for the ALU status logic.

Parameters:
- WIDTH, 4, operand/result width in bits.
- CNT_W, 8, width of the optional error counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  subtractor result presented.
- in_ready  output  1  stage can accept a result this cycle.
- in_a  input  WIDTH  minuend A as fed to the subtractor.
- in_b  input  WIDTH  subtrahend B.
- in_y  input  WIDTH  difference Y = A - B from the subtractor.
- out_valid  output  1  buffer head holds a valid result.
- out_ready  input  1  consumer accepts head this cycle.
- out_y  output  WIDTH  buffered difference.
- out_zero  output  1  Y == 0.
- out_neg  output  1  Y[WIDTH-1].
- out_borrow  output  1  unsigned A < B.
- out_ovf  output  1  signed overflow of A - B.
- clr_sticky  input  1  clears ovf_sticky (and err_count when enabled).
- ovf_sticky  output  1  set once any accepted result had out_ovf = 1.
- err_count  output  CNT_W  present only with SUB_ERR_COUNT_EN.

Behaviour:
- Reset (rst = 1 at edge): count = 0, head/tail pointers = 0, out_valid = 0, ovf_sticky = 0, err_count = 0. out_y and all flags read 0 while out_valid = 0. Reset overrides every other input, including a push or pop in the same cycle. In-flight entries are discarded.
- Push: in_valid & in_ready.
  - Stores in_y plus flags computed from in_a, in_b and in_y.
  - zero = (in_y == 0).
  - neg = in_y MSB.
  - borrow = (in_a < in_b), unsigned compare.
  - ovf = (in_a MSB != in_b MSB) & (in_y MSB != in_a MSB).
  - in_y is trusted; the stage does not recompute it.
- Pop: out_valid & out_ready. Advances head.
- in_ready = (count != 2). Combinational from registered count only; no dependence on out_ready.
- out_valid = (count != 0). The out_* data and flags always reflect the head entry.
- Latency: a result pushed at edge N appears at out_* after edge N when the buffer was empty (1 cycle).
- Count update:
  - push only: +1.
  - pop only: -1.
  - push & pop same cycle (count 1): count stays 1; the new entry becomes head after the pop.
  - count 0: pop impossible. Push sets count to 1.
  - count 2: push impossible. Pop sets count to 1.
- Pointers: 1-bit, wrap 1 -> 0.
- Ordering: strict FIFO; no drop, no duplication.
- Output stability: while out_valid = 1 and out_ready = 0, out_* are held constant.
- Sticky flag:
  - ovf_sticky is set on any push with ovf = 1.
  - clr_sticky clears it.
  - Set and clear in the same cycle: set wins, so ovf_sticky = 1.

Optional Feature:
- Macro SUB_ERR_COUNT_EN.
- Defined:
  - err_count port exists.
  - Increments by 1 on each push whose ovf or borrow is 1, saturating at 2^CNT_W - 1.
  - clr_sticky sets it to 0; an error push in the same cycle as clr_sticky sets it to 1.
  - Reset value 0.
- Undefined: no err_count port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset, then push A=0001, B=0001, Y=0000 with out_ready=1 -> next cycle out_valid=1, out_y=0000, zero=1, neg=0, borrow=0, ovf=0. Following cycle out_valid=0.
- Push A=1010, B=0011, Y=0111 -> out_y=0111, zero=0, neg=0, borrow=0, ovf=1, ovf_sticky=1. Then clr_sticky=1 alone -> ovf_sticky=0.
- Push A=0101, B=1001, Y=1100 -> neg=1, borrow=1, ovf=1. With SUB_ERR_COUNT_EN: err_count increments 0 -> 1. Assert clr_sticky during an error push -> err_count=1, ovf_sticky=1.
- Hold out_ready=0 and offer results Y=0111, Y=1001, Y=0001 back to back.
  - First two accepted; in_ready drops to 0 and the third stalls.
  - out_y holds at 0111.
  - Release out_ready -> pops return 0111, 1001, 0001 in order.
- With count=1, push and pop in the same cycle -> count stays 1, out_valid stays 1, out_y updates to the new entry the next cycle.
- With count=2, assert rst together with in_valid and out_ready -> next cycle out_valid=0, in_ready=1, ovf_sticky=0, err_count=0.

Source files
------------

// File: rtl/sub_result_stage.sv
// ---------------------------------------------------------------------------
// sub_result_stage
//
// Registered output stage that sits directly after the 4-bit subtractor.
// Each accepted result (in_y, with in_a/in_b) is stored in a 2-entry FIFO
// together with status flags worked out at capture time: zero, negative,
// unsigned borrow and signed overflow. Both sides use valid/ready
// handshakes. A sticky signed-overflow flag feeds the ALU status logic.
//
// Optional build macro: SUB_ERR_COUNT_EN
//   When defined, adds the err_count port. It is a saturating count of
//   accepted results that had ovf or borrow set. clr_sticky clears it.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous, active-high reset
//   in_valid    subtractor result presented
//   in_ready    stage can accept a result this cycle (depends on count only)
//   in_a        minuend A as fed to the subtractor
//   in_b        subtrahend B
//   in_y        difference Y = A - B (trusted, not recomputed)
//   out_valid   buffer head holds a valid result
//   out_ready   consumer accepts the head this cycle
//   out_y       head difference (0 while out_valid = 0)
//   out_zero    head Y == 0
//   out_neg     head Y MSB
//   out_borrow  head unsigned A < B
//   out_ovf     head signed overflow of A - B
//   clr_sticky  clears ovf_sticky (and err_count when enabled)
//   ovf_sticky  set once any accepted result had ovf = 1
//   err_count   saturating error-push count (SUB_ERR_COUNT_EN only)
// ---------------------------------------------------------------------------
module sub_result_stage #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_borrow,
    output logic             out_ovf,
    input  logic             clr_sticky,
    output logic             ovf_sticky
`ifdef SUB_ERR_COUNT_EN
    ,
    output logic [CNT_W-1:0] err_count
`endif
);

    // Reject parameter values the design cannot support at elaboration time.
    if (WIDTH < 2) begin : g_bad_width
        $error("sub_result_stage: WIDTH must be at least 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("sub_result_stage: CNT_W must be at least 1");
    end

    // Each entry is {ovf, borrow, neg, zero, y}.
    localparam int unsigned ENT_W = WIDTH + 4;

    logic [ENT_W-1:0] mem [2];
    logic [1:0]       count;
    logic             head;
    logic             tail;

    logic             push;
    logic             pop;
    logic             in_zero;
    logic             in_neg;
    logic             in_borrow;
    logic             in_ovf;
    logic [ENT_W-1:0] in_entry;
    logic [ENT_W-1:0] head_entry;

    // Flags come from the operands and the trusted difference. Overflow:
    // the operand signs differ and the result sign differs from A's sign.
    always_comb begin
        in_zero   = (in_y == '0);
        in_neg    = in_y[WIDTH-1];
        in_borrow = (in_a < in_b);
        in_ovf    = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                    (in_y[WIDTH-1] != in_a[WIDTH-1]);
        in_entry  = {in_ovf, in_borrow, in_neg, in_zero, in_y};
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Data and flags are forced to zero while the buffer is empty.
    always_comb begin
        head_entry = '0;
        if (out_valid) begin
            head_entry = mem[head];
        end
        {out_ovf, out_borrow, out_neg, out_zero, out_y} = head_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail] <= in_entry;
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            // A simultaneous push and pop leaves count unchanged.
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // A new overflow wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (push && in_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
        end
    end

`ifdef SUB_ERR_COUNT_EN
    localparam logic [CNT_W-1:0] ERR_ONE = 1;

    logic err_push;
    assign err_push = push && (in_ovf || in_borrow);

    // Clear restarts the count; an error push in the clearing cycle counts
    // as the first error after the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (clr_sticky) begin
            err_count <= err_push ? ERR_ONE : '0;
        end else if (err_push && (err_count != '1)) begin
            err_count <= err_count + ERR_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_sub_result_stage.sv
module tb_sub_result_stage;

    localparam int unsigned W      = 4;
    localparam int unsigned TB_CNT = 3;   // small counter so saturation is cheap

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [W-1:0]  in_y;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_y;
    logic          out_zero;
    logic          out_neg;
    logic          out_borrow;
    logic          out_ovf;
    logic          clr_sticky;
    logic          ovf_sticky;
`ifdef SUB_ERR_COUNT_EN
    logic [TB_CNT-1:0] err_count;
`endif

    int tests_run  = 0;
    int tests_fail = 0;

    sub_result_stage #(
        .WIDTH (W),
        .CNT_W (TB_CNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_y       (in_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_borrow (out_borrow),
        .out_ovf    (out_ovf),
        .clr_sticky (clr_sticky),
        .ovf_sticky (ovf_sticky)
`ifdef SUB_ERR_COUNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
        logic       zero;
        logic       neg;
        logic       borrow;
        logic       ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One rising edge, then return on the following falling edge where
    // outputs are sampled and new inputs are driven.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_y       = '0;
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] y);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_y     = y;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        //                a        b        y        z     n     b     o
        vecs[0] = '{4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'b1010, 4'b0011, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{4'b0101, 4'b1001, 4'b1100, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{4'b0000, 4'b0001, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{4'b0111, 4'b1111, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b1, 1'b1, 1'b0};
        // Inconsistent Y: flags must follow in_y as given, not A - B.
        vecs[8] = '{4'b0000, 4'b0000, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        do_reset();

        // ---- reset state ----
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_y",     {28'd0, out_y},     32'd0);
        check("rst_flags", {28'd0, out_zero, out_neg, out_borrow, out_ovf}, 32'd0);
        check("rst_sticky",    {31'd0, ovf_sticky}, 32'd0);
`ifdef SUB_ERR_COUNT_EN
        check("rst_err_count", {29'd0, err_count}, 32'd0);
`endif

        // ---- table-driven single pushes ----
        for (int i = 0; i < 9; i++) begin
            clr_sticky = 1'b1;
            step();
            clr_sticky = 1'b0;
            check($sformatf("v%0d_clr_sticky", i), {31'd0, ovf_sticky}, 32'd0);
`ifdef SUB_ERR_COUNT_EN
            check($sformatf("v%0d_clr_err", i), {29'd0, err_count}, 32'd0);
`endif
            drive(vecs[i].a, vecs[i].b, vecs[i].y);
            step();
            in_valid = 1'b0;
            check($sformatf("v%0d_valid", i),  {31'd0, out_valid}, 32'd1);
            check($sformatf("v%0d_y", i),      {28'd0, out_y}, {28'd0, vecs[i].y});
            check($sformatf("v%0d_zero", i),   {31'd0, out_zero},   {31'd0, vecs[i].zero});
            check($sformatf("v%0d_neg", i),    {31'd0, out_neg},    {31'd0, vecs[i].neg});
            check($sformatf("v%0d_borrow", i), {31'd0, out_borrow}, {31'd0, vecs[i].borrow});
            check($sformatf("v%0d_ovf", i),    {31'd0, out_ovf},    {31'd0, vecs[i].ovf});
            check($sformatf("v%0d_sticky", i), {31'd0, ovf_sticky}, {31'd0, vecs[i].ovf});
`ifdef SUB_ERR_COUNT_EN
            check($sformatf("v%0d_err", i), {29'd0, err_count},
                  {31'd0, vecs[i].ovf | vecs[i].borrow});
`endif
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check($sformatf("v%0d_drained", i), {31'd0, out_valid}, 32'd0);
            check($sformatf("v%0d_empty_data", i),
                  {27'd0, out_y, out_zero}, 32'd0);
        end

        // ---- sticky set/clear, set wins ----
        do_reset();
        drive(4'b1010, 4'b0011, 4'b0111);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("sticky_held", {31'd0, ovf_sticky}, 32'd1);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        check("sticky_cleared", {31'd0, ovf_sticky}, 32'd0);
        // two error pushes, then an error push together with clear
        drive(4'b0101, 4'b1001, 4'b1100);
        step();
        step();
`ifdef SUB_ERR_COUNT_EN
        check("err_two", {29'd0, err_count}, 32'd2);
`endif
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        in_valid   = 1'b0;
        check("sticky_set_wins", {31'd0, ovf_sticky}, 32'd1);
`ifdef SUB_ERR_COUNT_EN
        check("err_clr_with_push", {29'd0, err_count}, 32'd1);
        // saturation at 2^TB_CNT - 1 = 7
        drive(4'b0000, 4'b0001, 4'b1111);
        for (int k = 0; k < 9; k++) step();
        in_valid = 1'b0;
        check("err_saturated", {29'd0, err_count}, 32'd7);
`endif
        step();
        out_ready = 1'b0;

        // ---- backpressure and ordering ----
        do_reset();
        drive(4'b1010, 4'b0011, 4'b0111);
        check("bp_ready0", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_y_first", {28'd0, out_y}, 32'h7);
        check("bp_ready1", {31'd0, in_ready}, 32'd1);
        drive(4'b1100, 4'b0011, 4'b1001);
        step();
        check("bp_full_ready", {31'd0, in_ready}, 32'd0);
        check("bp_full_y", {28'd0, out_y}, 32'h7);
        drive(4'b0011, 4'b0010, 4'b0001);
        step();
        check("bp_stall_ready", {31'd0, in_ready}, 32'd0);
        check("bp_stall_y", {28'd0, out_y}, 32'h7);
        out_ready = 1'b1;
        step();
        check("bp_pop2_y", {28'd0, out_y}, 32'h9);
        check("bp_pop2_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_pop3_valid", {31'd0, out_valid}, 32'd1);
        check("bp_pop3_y", {28'd0, out_y}, 32'h1);
        step();
        check("bp_empty_valid", {31'd0, out_valid}, 32'd0);
        check("bp_empty_y", {28'd0, out_y}, 32'd0);
        out_ready = 1'b0;

        // ---- count 1: push and pop in the same cycle ----
        drive(4'b0110, 4'b0010, 4'b0100);
        step();
        check("pp_first_y", {28'd0, out_y}, 32'h4);
        drive(4'b0110, 4'b0001, 4'b0101);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("pp_valid", {31'd0, out_valid}, 32'd1);
        check("pp_y", {28'd0, out_y}, 32'h5);
        check("pp_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("pp_drained", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // ---- reset with a full buffer and live handshakes ----
        drive(4'b1010, 4'b0011, 4'b0111);
        step();
        drive(4'b0101, 4'b1001, 4'b1100);
        step();
        check("fr_full", {31'd0, in_ready}, 32'd0);
        rst       = 1'b1;
        out_ready = 1'b1;
        step();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("fr_valid", {31'd0, out_valid}, 32'd0);
        check("fr_ready", {31'd0, in_ready}, 32'd1);
        check("fr_sticky", {31'd0, ovf_sticky}, 32'd0);
        check("fr_y", {28'd0, out_y}, 32'd0);
`ifdef SUB_ERR_COUNT_EN
        check("fr_err", {29'd0, err_count}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
